// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester handshakes, multiplier issue/result port and the
// tagged response bus around mul_share_arbiter. The slave modport is the
// arbiter's view; master is the surrounding environment's view.
interface mul_share_arbiter_if #(
  parameter int N    = 4,
  parameter int SIZE = 8
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*SIZE-1:0]   req_a;
  logic [N*SIZE-1:0]   req_b;
  logic                mul_en_in;
  logic [SIZE-1:0]     mul_a;
  logic [SIZE-1:0]     mul_b;
  logic                mul_en_out;
  logic [2*SIZE-1:0]   mul_out;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2*SIZE-1:0]   rsp_data;
  logic                busy;
  logic                err_sync;

  modport slave (
    input  req_valid, req_a, req_b, mul_en_out, mul_out,
    output req_ready, mul_en_in, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_data, busy, err_sync
  );

  modport master (
    output req_valid, req_a, req_b, mul_en_out, mul_out,
    input  req_ready, mul_en_in, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_data, busy, err_sync
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier between N requesters.
// A tag pipeline follows every issued operation so the product coming out
// LAT cycles later can be returned to its owner on the response bus.
module mul_share_arbiter #(
  parameter int N    = 4,
  parameter int SIZE = 8,
  parameter int LAT  = 4
) (
  input logic                  clk,
  input logic                  rst,
  mul_share_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(N);

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    grant;
  logic [IDW-1:0]    ptr_next;
  logic              grant_found;
  logic              fire;
  logic [N-1:0]      ready;
  logic [SIZE-1:0]   sel_a;
  logic [SIZE-1:0]   sel_b;

  logic              tag_valid [0:LAT];
  logic [IDW-1:0]    tag_id    [0:LAT];
  logic              any_tag;

  logic              mul_en_in_q;
  logic [SIZE-1:0]   mul_a_q;
  logic [SIZE-1:0]   mul_b_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [2*SIZE-1:0] rsp_data_q;
  logic              err_q;

  // Pick the first valid requester at or above ptr, else wrap to the lowest one.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    sel_a       = '0;
    sel_b       = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_found && bus.req_valid[i] && (IDW'(i) >= ptr)) begin
        grant_found = 1'b1;
        grant       = IDW'(i);
        sel_a       = bus.req_a[i*SIZE +: SIZE];
        sel_b       = bus.req_b[i*SIZE +: SIZE];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_found && bus.req_valid[i]) begin
        grant_found = 1'b1;
        grant       = IDW'(i);
        sel_a       = bus.req_a[i*SIZE +: SIZE];
        sel_b       = bus.req_b[i*SIZE +: SIZE];
      end
    end
  end

  // One-hot ready for the winner, suppressed while in reset.
  always_comb begin
    ready = '0;
    fire  = grant_found && !rst;
    if (fire) ready[grant] = 1'b1;
    ptr_next = (grant == IDW'(N-1)) ? '0 : grant + 1'b1;
  end

  // Issue register toward the multiplier and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_en_in_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      ptr         <= '0;
    end else begin
      mul_en_in_q <= fire;
      if (fire) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
        ptr     <= ptr_next;
      end
    end
  end

  // Tag pipeline shifting every cycle; stage LAT lines up with the product strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LAT; k++) begin
        tag_valid[k] <= 1'b0;
        tag_id[k]    <= '0;
      end
    end else begin
      tag_valid[0] <= fire;
      tag_id[0]    <= grant;
      for (int k = 1; k <= LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  // Return matched products to their owner and latch any strobe/tag disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= bus.mul_en_out && tag_valid[LAT];
      if (bus.mul_en_out && tag_valid[LAT]) begin
        rsp_id_q   <= tag_id[LAT];
        rsp_data_q <= bus.mul_out;
      end
      if (bus.mul_en_out != tag_valid[LAT]) err_q <= 1'b1;
    end
  end

  // Anything still travelling through the tag pipeline keeps the block busy.
  always_comb begin
    any_tag = 1'b0;
    for (int k = 0; k <= LAT; k++) any_tag = any_tag | tag_valid[k];
  end

  assign bus.req_ready = ready;
  assign bus.mul_en_in = mul_en_in_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err_sync  = err_q;
  assign bus.busy      = mul_en_in_q | any_tag;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: a behavioural LAT-stage
// multiplier, a reference round-robin model and a response scoreboard.
module tb_mul_share_arbiter;
  localparam int N    = 4;
  localparam int SIZE = 8;
  localparam int LAT  = 4;

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  logic inject;

  mul_share_arbiter_if #(.N(N), .SIZE(SIZE)) bus();

  mul_share_arbiter #(.N(N), .SIZE(SIZE), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total;
  int   bad;
  int   cyc;
  int   mptr;
  int   pend_cnt [N];
  int   op_a     [N];
  int   op_b     [N];
  exp_t sb   [$];
  int   glog [$];
  int   gcyc [$];

  logic              pipe_en [1:LAT];
  logic [2*SIZE-1:0] pipe_p  [1:LAT];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure response latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier with fixed latency, reset together with the DUT.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= LAT; k++) pipe_en[k] <= 1'b0;
    end else begin
      pipe_en[1] <= bus.mul_en_in;
      pipe_p[1]  <= (2*SIZE)'(bus.mul_a) * (2*SIZE)'(bus.mul_b);
      for (int k = 2; k <= LAT; k++) begin
        pipe_en[k] <= pipe_en[k-1];
        pipe_p[k]  <= pipe_p[k-1];
      end
    end
  end

  assign bus.mul_en_out = pipe_en[LAT] | inject;
  assign bus.mul_out    = pipe_p[LAT];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input int count, input int a, input int b);
    op_a[id]     = a;
    op_b[id]     = b;
    pend_cnt[id] = count;
  endtask

  function automatic int pendTotal();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend_cnt[i];
    return s;
  endfunction

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((pendTotal() > 0 || sb.size() > 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", pendTotal(), 0);
    checkOutput("drain_scoreboard", sb.size(), 0);
    checkOutput("drain_busy", bus.busy, 0);
  endtask

  task automatic waitGrants(input int count, input int budget);
    int n = 0;
    while (glog.size() < count && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("grant_wait", glog.size(), count);
  endtask

  // Requester driver: raises valid while a requester still has operations queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i]              = (pend_cnt[i] > 0);
        bus.req_a[i*SIZE +: SIZE]     = op_a[i][SIZE-1:0];
        bus.req_b[i*SIZE +: SIZE]     = op_b[i][SIZE-1:0];
      end
    end
  end

  // Monitor: score responses, check arbitration against the reference model, log grants.
  always @(negedge clk) begin
    int   mg;
    int   idx;
    logic [N-1:0] exp_ready;
    exp_t e;
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", bus.rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_id", 32'(bus.rsp_id), e.id);
        checkOutput("rsp_data", 32'(bus.rsp_data), e.data);
        checkOutput("rsp_latency", cyc - e.cyc, LAT + 2);
      end
    end
    mg = -1;
    for (int k = 0; k < N; k++) begin
      idx = (mptr + k) % N;
      if (mg < 0 && bus.req_valid[idx]) mg = idx;
    end
    exp_ready = '0;
    if (!rst && mg >= 0) exp_ready[mg] = 1'b1;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (rst) begin
      mptr = 0;
      sb.delete();
    end else if (mg >= 0) begin
      sb.push_back('{id: mg, data: op_a[mg] * op_b[mg], cyc: cyc});
      pend_cnt[mg]--;
      glog.push_back(mg);
      gcyc.push_back(cyc);
      mptr = (mg + 1) % N;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_wrap [4];
    exp_wrap = '{3, 0, 3, 0};
    total = 0;
    bad = 0;
    cyc = 0;
    mptr = 0;
    inject = 1'b0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < N; i++) applyStimulus(i, 1, i + 1, 10);

    // Reset state, with all requesters already asking.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mul_en_in", bus.mul_en_in, 0);
    checkOutput("rst_mul_a", bus.mul_a, 0);
    checkOutput("rst_mul_b", bus.mul_b, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_id", bus.rsp_id, 0);
    checkOutput("rst_rsp_data", bus.rsp_data, 0);
    checkOutput("rst_err_sync", bus.err_sync, 0);
    checkOutput("rst_busy", bus.busy, 0);
    glog.delete();
    gcyc.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention: grants 0,1,2,3 back to back, products 10..40.
    waitDrain(60);
    checkOutput("cont_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) checkOutput("cont_order", glog[i], i);
    if (glog.size() == 4) checkOutput("cont_span", gcyc[3] - gcyc[0], 3);

    // Single request from requester 0.
    glog.delete();
    gcyc.delete();
    @(posedge clk);
    applyStimulus(0, 1, 200, 150);
    waitGrants(1, 20);
    @(negedge clk);
    checkOutput("single_mul_en_in", bus.mul_en_in, 1);
    checkOutput("single_mul_a", bus.mul_a, 200);
    checkOutput("single_mul_b", bus.mul_b, 150);
    checkOutput("single_busy", bus.busy, 1);
    @(negedge clk);
    checkOutput("single_en_drop", bus.mul_en_in, 0);
    waitDrain(40);
    checkOutput("single_product_seen", 32'(bus.rsp_data), 30000);

    // Streaming: 16 issues from requester 2.
    glog.delete();
    gcyc.delete();
    @(posedge clk);
    applyStimulus(2, 16, 255, 255);
    waitDrain(100);
    checkOutput("stream_count", glog.size(), 16);
    if (glog.size() == 16) begin
      checkOutput("stream_span", gcyc[15] - gcyc[0], 15);
      for (int i = 0; i < 16; i++) checkOutput("stream_id", glog[i], 2);
    end
    checkOutput("stream_rsp_data", 32'(bus.rsp_data), 65025);
    checkOutput("stream_err_sync", bus.err_sync, 0);

    // Wrap and fairness: ptr is now 3, requesters 3 and 0 both busy.
    glog.delete();
    gcyc.delete();
    @(posedge clk);
    applyStimulus(3, 2, 3, 5);
    applyStimulus(0, 2, 11, 13);
    waitDrain(60);
    checkOutput("wrap_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) checkOutput("wrap_order", glog[i], exp_wrap[i]);

    // Sync fault: spurious multiplier strobe with nothing in flight.
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    @(negedge clk);
    checkOutput("fault_err_set", bus.err_sync, 1);
    repeat (5) @(negedge clk);
    checkOutput("fault_err_held", bus.err_sync, 1);
    checkOutput("fault_no_rsp", bus.rsp_valid, 0);

    // Reset mid-flight: three ops from requester 1, then reset DUT and multiplier.
    glog.delete();
    gcyc.delete();
    @(posedge clk);
    applyStimulus(1, 3, 9, 9);
    waitGrants(3, 20);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_mul_en_in", bus.mul_en_in, 0);
    checkOutput("mid_mul_a", bus.mul_a, 0);
    checkOutput("mid_mul_b", bus.mul_b, 0);
    checkOutput("mid_rsp_valid", bus.rsp_valid, 0);
    checkOutput("mid_rsp_id", bus.rsp_id, 0);
    checkOutput("mid_rsp_data", bus.rsp_data, 0);
    checkOutput("mid_err_sync", bus.err_sync, 0);
    checkOutput("mid_busy", bus.busy, 0);
    repeat (LAT + 4) @(negedge clk);
    checkOutput("mid_err_after", bus.err_sync, 0);
    @(posedge clk);
    applyStimulus(0, 1, 7, 9);
    waitDrain(40);
    checkOutput("post_rsp_data", 32'(bus.rsp_data), 63);
    checkOutput("post_rsp_id", bus.rsp_id, 0);
    checkOutput("post_err_sync", bus.err_sync, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
